// File: rtl/rv_pkg.sv
// Shared types for the segmented RV32I core: decoded control bundle and constants.
package rv_pkg;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ru_wr;
    logic       dm_wr;
    logic       dm_rd;
    logic [2:0] dm_ctrl;
    logic [1:0] wb_sel;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t      CTRL_NOP = '0;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose rd is read by the ID instruction.
module load_use_detect
  import rv_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_dm_rd,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       lu
);

  logic hit_rs1;
  logic hit_rs2;

  // x0 is never a real producer, so a load to x0 must not stall.
  assign hit_rs1 = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit_rs2 = id_use_rs2 && (id_rs2 == ex_rd);
  assign lu      = ex_valid && ex_dm_rd && (ex_rd != REG_ZERO) && id_valid
                   && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and a saturating bubble counter.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_ru1,
  input  logic [XLEN-1:0]  id_ru2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  ctrl_t            id_ctrl,
  input  logic             flush,
  output logic             stall_o,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_ru1,
  output logic [XLEN-1:0]  ex_ru2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output ctrl_t            ex_ctrl,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic lu;
  logic bubble;

  load_use_detect u_lud (
    .ex_valid   (ex_valid),
    .ex_dm_rd   (ex_ctrl.dm_rd),
    .ex_rd      (ex_rd),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .lu         (lu)
  );

  // Hold semantics: while stall_o is high, PC and IF/ID keep their contents and ID
  // re-presents the same instruction next cycle; a flush overrides the stall because
  // the ID instruction is being discarded anyway.
  assign stall_o = lu && !flush;
  assign bubble  = flush || stall_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
      ex_pc    <= '0;
      ex_ru1   <= '0;
      ex_ru2   <= '0;
      ex_imm   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
    end else if (bubble) begin
      // Data fields stay stale; a NOP control bundle makes them harmless.
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
    end else begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
      ex_pc    <= id_pc;
      ex_ru1   <= id_ru1;
      ex_ru2   <= id_ru2;
      ex_imm   <= id_imm;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus reset and saturation sequences.
module tb_id_ex_stage;
  import rv_pkg::*;

  localparam ctrl_t C_ADD = '{alu_op:4'd0, alu_src_a:1'b0, alu_src_b:1'b0, ru_wr:1'b1,
                              dm_wr:1'b0, dm_rd:1'b0, dm_ctrl:3'b000, wb_sel:2'b00,
                              branch:1'b0, jump:1'b0};
  localparam ctrl_t C_LW  = '{alu_op:4'd0, alu_src_a:1'b0, alu_src_b:1'b1, ru_wr:1'b1,
                              dm_wr:1'b0, dm_rd:1'b1, dm_ctrl:3'b010, wb_sel:2'b01,
                              branch:1'b0, jump:1'b0};
  localparam ctrl_t C_LUI = '{alu_op:4'd10, alu_src_a:1'b1, alu_src_b:1'b1, ru_wr:1'b1,
                              dm_wr:1'b0, dm_rd:1'b0, dm_ctrl:3'b000, wb_sel:2'b00,
                              branch:1'b0, jump:1'b0};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        id_valid, id_use_rs1, id_use_rs2, flush;
  logic [31:0] id_pc, id_ru1, id_ru2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  ctrl_t       id_ctrl;

  logic        stall_o, ex_valid;
  logic [31:0] ex_pc, ex_ru1, ex_ru2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  ctrl_t       ex_ctrl;
  logic [15:0] bubble_cnt;

  logic        s_stall_o, s_ex_valid;
  logic [31:0] s_ex_pc, s_ex_ru1, s_ex_ru2, s_ex_imm;
  logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  ctrl_t       s_ex_ctrl;
  logic [3:0]  s_bubble_cnt;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_ru1(id_ru1),
    .id_ru2(id_ru2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ctrl(id_ctrl), .flush(flush),
    .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ru1(ex_ru1),
    .ex_ru2(ex_ru2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_ru1(id_ru1),
    .id_ru2(id_ru2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ctrl(id_ctrl), .flush(flush),
    .stall_o(s_stall_o), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_ru1(s_ex_ru1),
    .ex_ru2(s_ex_ru2), .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2),
    .ex_rd(s_ex_rd), .ex_ctrl(s_ex_ctrl), .bubble_cnt(s_bubble_cnt)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc, ru1, ru2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    ctrl_t       ctrl;
    logic        fl;
    logic        e_stall;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic v, input logic [31:0] pc, input logic [31:0] ru1,
                         input logic [31:0] ru2, input logic [31:0] imm, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                         input logic u2, input ctrl_t ctrl, input logic fl,
                         input logic e_stall, input logic e_valid, input logic [15:0] e_cnt);
    vec_t t;
    t.v = v; t.pc = pc; t.ru1 = ru1; t.ru2 = ru2; t.imm = imm;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2;
    t.ctrl = ctrl; t.fl = fl; t.e_stall = e_stall; t.e_valid = e_valid; t.e_cnt = e_cnt;
    vecs.push_back(t);
  endtask

  // driver
  task automatic drive(input vec_t t);
    id_valid = t.v; id_pc = t.pc; id_ru1 = t.ru1; id_ru2 = t.ru2; id_imm = t.imm;
    id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
    id_ctrl = t.ctrl; flush = t.fl;
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_pc = '0; id_ru1 = '0; id_ru2 = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_ctrl = CTRL_NOP; flush = 1'b0;
  endtask

  initial begin
    //      v  pc       ru1      ru2   imm  rs1 rs2 rd u1 u2 ctrl  fl | stall valid cnt
    add_vec(1, 32'h100, 32'd5,   32'd7, 0,   1,  2,  3, 1, 1, C_ADD, 0,   0,    1,   0); // ADD x3
    add_vec(1, 32'h104, 32'h40,  32'd0, 4,   2,  0,  5, 1, 0, C_LW,  0,   0,    1,   0); // LW x5
    add_vec(1, 32'h108, 32'd9,   32'd3, 0,   5,  1,  6, 1, 1, C_ADD, 0,   1,    0,   1); // stall
    add_vec(1, 32'h108, 32'h77,  32'd3, 0,   5,  1,  6, 1, 1, C_ADD, 0,   0,    1,   1); // replay
    add_vec(1, 32'h10c, 32'd1,   32'd0, 8,   1,  0,  0, 1, 0, C_LW,  0,   0,    1,   1); // LW x0
    add_vec(1, 32'h110, 32'd0,   32'd2, 0,   0,  2,  7, 1, 1, C_ADD, 0,   0,    1,   1); // use x0
    add_vec(1, 32'h114, 32'd1,   32'd0, 0,   1,  0,  5, 1, 0, C_LW,  0,   0,    1,   1); // LW x5
    add_vec(1, 32'h118, 32'd0,   32'd0, 32'h5000, 5, 5, 5, 0, 0, C_LUI, 0, 0,  1,   1); // LUI x5
    add_vec(1, 32'h11c, 32'd1,   32'd0, 0,   1,  0,  8, 1, 0, C_LW,  0,   0,    1,   1); // LW x8
    add_vec(1, 32'h120, 32'd1,   32'd2, 0,   1,  8,  9, 1, 1, C_ADD, 1,   0,    0,   2); // flush+lu
    add_vec(0, 32'h0,   32'd0,   32'd0, 0,   0,  0,  0, 0, 0, C_ADD, 0,   0,    0,   2); // idle
    add_vec(1, 32'h200, 32'd3,   32'd0, 0,   3,  0,  4, 1, 0, C_LW,  0,   0,    1,   2); // LW x4
    add_vec(0, 32'h204, 32'd0,   32'd0, 0,   4,  4,  1, 1, 1, C_ADD, 0,   0,    0,   2); // invalid ID
    add_vec(1, 32'h208, 32'd3,   32'd0, 0,   3,  0, 10, 1, 0, C_LW,  0,   0,    1,   2); // LW x10
    add_vec(1, 32'h20c, 32'd6,   32'd8, 0,  10, 11, 12, 0, 1, C_ADD, 0,   0,    1,   2); // rs1 unused

    drive_idle();
    #2;
    check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset_ex_ctrl", {16'd0, ex_ctrl}, {16'd0, CTRL_NOP});
    check("reset_cnt", {16'd0, bubble_cnt}, 32'd0);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_cnt", i), {16'd0, bubble_cnt}, {16'd0, vecs[i].e_cnt});
      exp_q.push_back({16'd0, (vecs[i].e_valid ? vecs[i].ctrl : CTRL_NOP)});
      check($sformatf("v%0d_ctrl", i), {16'd0, ex_ctrl}, exp_q.pop_front());
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
        check($sformatf("v%0d_ru1", i), ex_ru1, vecs[i].ru1);
        check($sformatf("v%0d_ru2", i), ex_ru2, vecs[i].ru2);
        check($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
        check($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
      end
    end

    // Reset asserted mid-run while a stall is pending and EX holds a valid load.
    @(negedge clk);
    drive(vecs[1]);
    @(negedge clk);
    drive(vecs[2]);
    #1;
    check("mid_stall_pre", {31'd0, stall_o}, 32'd1);
    check("mid_valid_pre", {31'd0, ex_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_async_ctrl", {16'd0, ex_ctrl}, {16'd0, CTRL_NOP});
    check("rst_async_cnt", {16'd0, bubble_cnt}, 32'd0);
    check("rst_async_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_release_valid", {31'd0, ex_valid}, 32'd1);
    check("rst_release_rd", {27'd0, ex_rd}, 32'd6);
    check("rst_release_cnt", {16'd0, bubble_cnt}, 32'd0);

    // Twenty consecutive flushes: the 4-bit counter must stick at 15.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      drive_idle();
      flush = 1'b1;
      @(posedge clk);
      #1;
      if (k == 15 || k == 16 || k == 20) begin
        check($sformatf("sat_small_k%0d", k), {28'd0, s_bubble_cnt}, 32'd15);
        check($sformatf("sat_wide_k%0d", k), {16'd0, bubble_cnt}, k);
      end
    end
    check("sat_valid", {31'd0, s_ex_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
